// File: rtl/pcie_flow_ctrl_init_rx.sv
// -----------------------------------------------------------------------------
// pcie_flow_ctrl_init_rx
//
// Receive side of PCIe data-link flow-control initialisation.
// - Parses InitFC1/InitFC2 DLLPs from a 32-bit AXIS stream of two beats:
//   beat 1 carries the 4 DLLP bytes, beat 2 carries ~CRC16 in tdata[15:0].
// - Checks the DLLP CRC16 and stores the VC0 header/data credits for P, NP
//   and Cpl.
// - Flags completion of the FC1 and FC2 phases for the transmitter.
//
// Optional feature macro: PCIE_FC_SCALE_EN
//   defined   : hdr_scale_o / data_scale_o capture the per-type scale fields.
//   undefined : both scale outputs are tied to zero.
//
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   start_flow_control_i     FC init active; low clears flags/credits/counter
//   s_axis_*                 DLLP beat stream (tkeep/tuser not interpreted)
//   fc1_values_stored_o      P, NP and Cpl credits all captured (sticky)
//   fc2_values_stored_o      InitFC2 seen after FC1 complete (sticky)
//   hdr_fc_*_o, data_fc_*_o  stored header (8b) / data (12b) credits
//   hdr_scale_o, data_scale_o {Cpl,NP,P} 2-bit scale fields
//   crc_err_o, malformed_o   one-cycle error pulses
//   crc_err_count_o          saturating CRC error count
// -----------------------------------------------------------------------------

// Serial DLLP CRC16 (poly 0x100B), data consumed byte 0 first, LSB first.
module pcie_datalink_crc (
  input  logic [31:0] data_i,
  input  logic [15:0] crc_in_i,
  output logic [15:0] crc_out_o
);

  function automatic logic [15:0] crc16_step32(input logic [15:0] crc_in,
                                               input logic [31:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc_in;
    for (int i = 0; i < 32; i++) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h100B : 16'h0000);
    end
    return c;
  endfunction

  // CRC over one full 32-bit beat
  always_comb begin
    crc_out_o = crc16_step32(crc_in_i, data_i);
  end

endmodule

module pcie_flow_ctrl_init_rx #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int USER_WIDTH = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_flow_control_i,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic                  s_axis_tready,
  output logic                  fc1_values_stored_o,
  output logic                  fc2_values_stored_o,
  output logic [7:0]            hdr_fc_p_o,
  output logic [7:0]            hdr_fc_np_o,
  output logic [7:0]            hdr_fc_cpl_o,
  output logic [11:0]           data_fc_p_o,
  output logic [11:0]           data_fc_np_o,
  output logic [11:0]           data_fc_cpl_o,
  output logic [5:0]            hdr_scale_o,
  output logic [5:0]            data_scale_o,
  output logic                  crc_err_o,
  output logic                  malformed_o,
  output logic [7:0]            crc_err_count_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CRC    = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  localparam logic [4:0] TYPE_FC1_P   = 5'h08;
  localparam logic [4:0] TYPE_FC1_NP  = 5'h0A;
  localparam logic [4:0] TYPE_FC1_CPL = 5'h0C;
  localparam logic [4:0] TYPE_FC2_P   = 5'h18;
  localparam logic [4:0] TYPE_FC2_NP  = 5'h1A;
  localparam logic [4:0] TYPE_FC2_CPL = 5'h1C;

  localparam logic [1:0] KIND_P    = 2'd0;
  localparam logic [1:0] KIND_NP   = 2'd1;
  localparam logic [1:0] KIND_CPL  = 2'd2;
  localparam logic [1:0] KIND_NONE = 2'd3;

  // Map a DLLP type code onto the credit class it updates.
  function automatic logic [1:0] fc_kind(input logic [4:0] t);
    logic [1:0] k;
    case (t)
      TYPE_FC1_P,   TYPE_FC2_P:   k = KIND_P;
      TYPE_FC1_NP,  TYPE_FC2_NP:  k = KIND_NP;
      TYPE_FC1_CPL, TYPE_FC2_CPL: k = KIND_CPL;
      default:                    k = KIND_NONE;
    endcase
    return k;
  endfunction

  state_e      state_q;
  logic        tready_q;
  logic [15:0] crc_q;
  logic [4:0]  type_q;
  logic [2:0]  vc_q;
  logic [7:0]  hdr_q;
  logic [11:0] data_q;
  logic        crc_err_q;
  logic        malformed_q;
  logic [7:0]  err_cnt_q;
  logic [7:0]  err_cnt_d;

  logic [7:0]  hdr_p_q, hdr_np_q, hdr_cpl_q;
  logic [11:0] data_p_q, data_np_q, data_cpl_q;
  logic [2:0]  recv_q;
  logic        fc1_q;
  logic        fc2_q;

  logic [7:0]  byte0_s, byte1_s, byte2_s, byte3_s;
  logic [15:0] crc_out_s;
  logic        beat_hs_s;
  logic        commit_s;
  logic [1:0]  kind_s;
  logic        unused_s;

  assign byte0_s   = s_axis_tdata[7:0];
  assign byte1_s   = s_axis_tdata[15:8];
  assign byte2_s   = s_axis_tdata[23:16];
  assign byte3_s   = s_axis_tdata[31:24];
  assign beat_hs_s = s_axis_tvalid & tready_q;
  assign unused_s  = ^{s_axis_tkeep, s_axis_tuser};

  pcie_datalink_crc u_crc (
    .data_i    (s_axis_tdata[31:0]),
    .crc_in_i  (16'hFFFF),
    .crc_out_o (crc_out_s)
  );

  // Saturating next value of the CRC error counter
  always_comb begin
    if (err_cnt_q == 8'hFF) begin
      err_cnt_d = 8'hFF;
    end else begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

`ifdef PCIE_FC_SCALE_EN
  logic [1:0] hscale_q, dscale_q;
  logic [5:0] hdr_scale_q, data_scale_q;
`endif

  // DLLP framing FSM: beat capture, CRC check, one-cycle commit slot
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      tready_q    <= 1'b0;
      crc_q       <= 16'h0000;
      type_q      <= 5'h00;
      vc_q        <= 3'd0;
      hdr_q       <= 8'h00;
      data_q      <= 12'h000;
      crc_err_q   <= 1'b0;
      malformed_q <= 1'b0;
      err_cnt_q   <= 8'h00;
`ifdef PCIE_FC_SCALE_EN
      hscale_q    <= 2'd0;
      dscale_q    <= 2'd0;
`endif
    end else if (!start_flow_control_i) begin
      // Keep draining the stream but drop any partial DLLP.
      state_q     <= ST_IDLE;
      tready_q    <= 1'b1;
      crc_err_q   <= 1'b0;
      malformed_q <= 1'b0;
      err_cnt_q   <= 8'h00;
    end else begin
      crc_err_q   <= 1'b0;
      malformed_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tready_q <= 1'b1;
          if (beat_hs_s) begin
            if (s_axis_tlast) begin
              malformed_q <= 1'b1;
            end else begin
              type_q  <= byte0_s[7:3];
              vc_q    <= byte0_s[2:0];
              hdr_q   <= {byte1_s[5:0], byte2_s[7:6]};
              data_q  <= {byte2_s[3:0], byte3_s};
              crc_q   <= crc_out_s;
`ifdef PCIE_FC_SCALE_EN
              hscale_q <= byte1_s[7:6];
              dscale_q <= byte2_s[5:4];
`endif
              state_q <= ST_CRC;
            end
          end
        end
        ST_CRC: begin
          tready_q <= 1'b1;
          if (beat_hs_s) begin
            if (s_axis_tlast) begin
              if (s_axis_tdata[15:0] == ~crc_q) begin
                state_q  <= ST_COMMIT;
                tready_q <= 1'b0;   // hold off the next DLLP for the commit slot
              end else begin
                crc_err_q <= 1'b1;
                err_cnt_q <= err_cnt_d;
                state_q   <= ST_IDLE;
              end
            end else begin
              // Extra non-last beat: flag it and keep waiting for tlast.
              malformed_q <= 1'b1;
            end
          end
        end
        ST_COMMIT: begin
          state_q  <= ST_IDLE;
          tready_q <= 1'b1;
        end
        default: begin
          state_q  <= ST_IDLE;
          tready_q <= 1'b1;
        end
      endcase
    end
  end

  assign commit_s = (state_q == ST_COMMIT) && (vc_q == 3'd0);
  assign kind_s   = fc_kind(type_q);

  // Credit storage and FC1/FC2 completion flags
  always_ff @(posedge clk_i) begin
    if (!rst_ni || !start_flow_control_i) begin
      hdr_p_q    <= 8'h00;
      hdr_np_q   <= 8'h00;
      hdr_cpl_q  <= 8'h00;
      data_p_q   <= 12'h000;
      data_np_q  <= 12'h000;
      data_cpl_q <= 12'h000;
      recv_q     <= 3'b000;
      fc1_q      <= 1'b0;
      fc2_q      <= 1'b0;
`ifdef PCIE_FC_SCALE_EN
      hdr_scale_q  <= 6'd0;
      data_scale_q <= 6'd0;
`endif
    end else begin
      // FC1 completes the cycle after the last received bit lands.
      fc1_q <= fc1_q | (&recv_q);
      if (commit_s) begin
        case (kind_s)
          KIND_P: begin
            hdr_p_q   <= hdr_q;
            data_p_q  <= data_q;
            recv_q[0] <= 1'b1;
`ifdef PCIE_FC_SCALE_EN
            hdr_scale_q[1:0]  <= hscale_q;
            data_scale_q[1:0] <= dscale_q;
`endif
          end
          KIND_NP: begin
            hdr_np_q  <= hdr_q;
            data_np_q <= data_q;
            recv_q[1] <= 1'b1;
`ifdef PCIE_FC_SCALE_EN
            hdr_scale_q[3:2]  <= hscale_q;
            data_scale_q[3:2] <= dscale_q;
`endif
          end
          KIND_CPL: begin
            hdr_cpl_q  <= hdr_q;
            data_cpl_q <= data_q;
            recv_q[2]  <= 1'b1;
`ifdef PCIE_FC_SCALE_EN
            hdr_scale_q[5:4]  <= hscale_q;
            data_scale_q[5:4] <= dscale_q;
`endif
          end
          default: begin
            recv_q <= recv_q;
          end
        endcase
        // InitFC2 types have bit 4 of the type code set.
        if ((kind_s != KIND_NONE) && type_q[4] && fc1_q) begin
          fc2_q <= 1'b1;
        end
      end
    end
  end

  assign s_axis_tready       = tready_q;
  assign fc1_values_stored_o = fc1_q;
  assign fc2_values_stored_o = fc2_q;
  assign hdr_fc_p_o          = hdr_p_q;
  assign hdr_fc_np_o         = hdr_np_q;
  assign hdr_fc_cpl_o        = hdr_cpl_q;
  assign data_fc_p_o         = data_p_q;
  assign data_fc_np_o        = data_np_q;
  assign data_fc_cpl_o       = data_cpl_q;
  assign crc_err_o           = crc_err_q;
  assign malformed_o         = malformed_q;
  assign crc_err_count_o     = err_cnt_q;
`ifdef PCIE_FC_SCALE_EN
  assign hdr_scale_o         = hdr_scale_q;
  assign data_scale_o        = data_scale_q;
`else
  assign hdr_scale_o         = 6'd0;
  assign data_scale_o        = 6'd0;
`endif

endmodule

// File: tb/tb_pcie_flow_ctrl_init_rx.sv
// Self-checking bench for pcie_flow_ctrl_init_rx: directed vector table,
// timing sequences for the multi-cycle corners, then random DLLPs checked
// against a transaction-level credit model.
module tb_pcie_flow_ctrl_init_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_fc;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tkeep;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic [2:0]  s_axis_tuser;
  logic        s_axis_tready;
  logic        fc1, fc2;
  logic [7:0]  hdr_p, hdr_np, hdr_cpl;
  logic [11:0] data_p, data_np, data_cpl;
  logic [5:0]  hdr_scale, data_scale;
  logic        crc_err, malformed;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pcie_flow_ctrl_init_rx dut (
    .clk_i                (clk),
    .rst_ni               (rst_n),
    .start_flow_control_i (start_fc),
    .s_axis_tdata         (s_axis_tdata),
    .s_axis_tkeep         (s_axis_tkeep),
    .s_axis_tvalid        (s_axis_tvalid),
    .s_axis_tlast         (s_axis_tlast),
    .s_axis_tuser         (s_axis_tuser),
    .s_axis_tready        (s_axis_tready),
    .fc1_values_stored_o  (fc1),
    .fc2_values_stored_o  (fc2),
    .hdr_fc_p_o           (hdr_p),
    .hdr_fc_np_o          (hdr_np),
    .hdr_fc_cpl_o         (hdr_cpl),
    .data_fc_p_o          (data_p),
    .data_fc_np_o         (data_np),
    .data_fc_cpl_o        (data_cpl),
    .hdr_scale_o          (hdr_scale),
    .data_scale_o         (data_scale),
    .crc_err_o            (crc_err),
    .malformed_o          (malformed),
    .crc_err_count_o      (err_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // CRC16, generator x^16+x^12+x^3+x+1, seed FFFF, bytes in order, LSB first.
  function automatic logic [15:0] crc_ref(input logic [31:0] w);
    logic [15:0] c;
    logic [7:0]  b;
    c = 16'hFFFF;
    for (int k = 0; k < 4; k++) begin
      b = w[8*k +: 8];
      for (int j = 0; j < 8; j++) begin
        if (c[15] != b[j]) c = (c << 1) ^ 16'h100B;
        else               c = c << 1;
      end
    end
    return c;
  endfunction

  function automatic logic [31:0] make_beat1(input logic [7:0] tbyte, input logic [7:0] hdr,
                                             input logic [11:0] data, input logic [1:0] hs,
                                             input logic [1:0] ds);
    logic [7:0] b1, b2, b3;
    b1 = {hs, hdr[7:2]};
    b2 = {hdr[1:0], ds, data[11:8]};
    b3 = data[7:0];
    return {b3, b2, b1, tbyte};
  endfunction

  // Drive one beat and return #1 after the edge on which it was accepted.
  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int n = 0;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    while (s_axis_tready !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL tready_timeout: got %0b expected 1", s_axis_tready);
    end
    tick(1);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_dllp(input logic [7:0] tbyte, input logic [7:0] hdr, input logic [11:0] data,
                           input logic [1:0] hs, input logic [1:0] ds, input logic bad);
    logic [31:0] w;
    logic [15:0] c;
    w = make_beat1(tbyte, hdr, data, hs, ds);
    c = ~crc_ref(w);
    if (bad) c[0] = ~c[0];
    send_beat(w, 4'hF, 1'b0);
    send_beat({16'h0000, c}, 4'h3, 1'b1);
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [7:0]  m_hdr [3];
  logic [11:0] m_data[3];
  logic [1:0]  m_hs  [3];
  logic [1:0]  m_ds  [3];
  bit          m_recv[3];
  bit          m_fc1, m_fc2;
  int          m_cnt;

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      m_hdr[i] = 8'h00; m_data[i] = 12'h000; m_hs[i] = 2'd0; m_ds[i] = 2'd0; m_recv[i] = 1'b0;
    end
    m_fc1 = 1'b0; m_fc2 = 1'b0; m_cnt = 0;
  endtask

  task automatic model_apply(input logic [7:0] tbyte, input logic [7:0] hdr, input logic [11:0] data,
                             input logic [1:0] hs, input logic [1:0] ds, input logic bad);
    int t, idx;
    if (bad) begin
      if (m_cnt < 255) m_cnt++;
      return;
    end
    t = int'(tbyte[7:3]);
    case (t)
      8'h08, 8'h18: idx = 0;
      8'h0A, 8'h1A: idx = 1;
      8'h0C, 8'h1C: idx = 2;
      default:      idx = -1;
    endcase
    if (tbyte[2:0] == 3'd0 && idx >= 0) begin
      m_hdr[idx] = hdr; m_data[idx] = data; m_hs[idx] = hs; m_ds[idx] = ds;
      m_recv[idx] = 1'b1;
      if (t >= 8'h18 && m_fc1) m_fc2 = 1'b1;
    end
    if (m_recv[0] && m_recv[1] && m_recv[2]) m_fc1 = 1'b1;
  endtask

  task automatic model_check(input string tag);
    chk({tag, "_fc1"}, fc1, m_fc1);
    chk({tag, "_fc2"}, fc2, m_fc2);
    chk({tag, "_cnt"}, err_cnt, m_cnt);
    chk({tag, "_hdr_p"}, hdr_p, m_hdr[0]);
    chk({tag, "_hdr_np"}, hdr_np, m_hdr[1]);
    chk({tag, "_hdr_cpl"}, hdr_cpl, m_hdr[2]);
    chk({tag, "_data_p"}, data_p, m_data[0]);
    chk({tag, "_data_np"}, data_np, m_data[1]);
    chk({tag, "_data_cpl"}, data_cpl, m_data[2]);
`ifdef PCIE_FC_SCALE_EN
    chk({tag, "_hscale"}, hdr_scale, {m_hs[2], m_hs[1], m_hs[0]});
    chk({tag, "_dscale"}, data_scale, {m_ds[2], m_ds[1], m_ds[0]});
`else
    chk({tag, "_hscale"}, hdr_scale, 6'd0);
    chk({tag, "_dscale"}, data_scale, 6'd0);
`endif
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [7:0]  tbyte;
    logic [7:0]  hdr;
    logic [11:0] data;
    logic        bad;
    logic        e_fc1;
    logic        e_fc2;
    logic [7:0]  e_cnt;
    logic [7:0]  e_hp;
    logic [7:0]  e_hnp;
    logic [7:0]  e_hcpl;
    logic [11:0] e_dp;
    logic [11:0] e_dcpl;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [31:0] w;
    logic [15:0] c;
    logic [7:0]  tb_t, tb_h;
    logic [11:0] tb_d;
    logic [1:0]  tb_hs, tb_ds;
    logic        tb_bad;
    int          r;

    vecs[0] = '{8'hC0, 8'h11, 12'h005, 1'b0, 1'b0, 1'b0, 8'd0, 8'h11, 8'h00, 8'h00, 12'h005, 12'h000};
    vecs[1] = '{8'h40, 8'h20, 12'h010, 1'b0, 1'b0, 1'b0, 8'd0, 8'h20, 8'h00, 8'h00, 12'h010, 12'h000};
    vecs[2] = '{8'h40, 8'h33, 12'h0FF, 1'b1, 1'b0, 1'b0, 8'd1, 8'h20, 8'h00, 8'h00, 12'h010, 12'h000};
    vecs[3] = '{8'h51, 8'h44, 12'h0AB, 1'b0, 1'b0, 1'b0, 8'd1, 8'h20, 8'h00, 8'h00, 12'h010, 12'h000};
    vecs[4] = '{8'h50, 8'h20, 12'h010, 1'b0, 1'b0, 1'b0, 8'd1, 8'h20, 8'h20, 8'h00, 12'h010, 12'h000};
    vecs[5] = '{8'h38, 8'h55, 12'h055, 1'b0, 1'b0, 1'b0, 8'd1, 8'h20, 8'h20, 8'h00, 12'h010, 12'h000};
    vecs[6] = '{8'h60, 8'h20, 12'h010, 1'b0, 1'b1, 1'b0, 8'd1, 8'h20, 8'h20, 8'h20, 12'h010, 12'h010};
    vecs[7] = '{8'hC0, 8'h20, 12'h010, 1'b0, 1'b1, 1'b1, 8'd1, 8'h20, 8'h20, 8'h20, 12'h010, 12'h010};
    vecs[8] = '{8'hE0, 8'h00, 12'h000, 1'b0, 1'b1, 1'b1, 8'd1, 8'h20, 8'h20, 8'h00, 12'h010, 12'h000};

    rst_n = 1'b0; start_fc = 1'b0;
    s_axis_tdata = 32'h0; s_axis_tkeep = 4'h0; s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0; s_axis_tuser = 3'd0;

    // Reset state
    tick(3);
    chk("rst_tready", s_axis_tready, 1'b0);
    chk("rst_fc1", fc1, 1'b0);
    chk("rst_fc2", fc2, 1'b0);
    chk("rst_hdr_p", hdr_p, 8'h00);
    chk("rst_data_cpl", data_cpl, 12'h000);
    chk("rst_cnt", err_cnt, 8'h00);
    chk("rst_crc_err", crc_err, 1'b0);
    chk("rst_malformed", malformed, 1'b0);
    rst_n = 1'b1;
    tick(1);
    chk("idle_tready", s_axis_tready, 1'b1);
    start_fc = 1'b1;
    tick(1);

    // Table: settle each DLLP then compare against the hand-derived values
    for (int i = 0; i < 9; i++) begin
      send_dllp(vecs[i].tbyte, vecs[i].hdr, vecs[i].data, 2'b11, 2'b10, vecs[i].bad);
      tick(2);
      chk($sformatf("vec%0d_fc1", i), fc1, vecs[i].e_fc1);
      chk($sformatf("vec%0d_fc2", i), fc2, vecs[i].e_fc2);
      chk($sformatf("vec%0d_cnt", i), err_cnt, vecs[i].e_cnt);
      chk($sformatf("vec%0d_hdr_p", i), hdr_p, vecs[i].e_hp);
      chk($sformatf("vec%0d_hdr_np", i), hdr_np, vecs[i].e_hnp);
      chk($sformatf("vec%0d_hdr_cpl", i), hdr_cpl, vecs[i].e_hcpl);
      chk($sformatf("vec%0d_data_p", i), data_p, vecs[i].e_dp);
      chk($sformatf("vec%0d_data_cpl", i), data_cpl, vecs[i].e_dcpl);
      chk($sformatf("vec%0d_data_np", i), data_np, (i >= 4) ? 12'h010 : 12'h000);
      chk($sformatf("vec%0d_hscale", i), hdr_scale,
`ifdef PCIE_FC_SCALE_EN
          hdr_scale);  // scale build: covered by the random model phase
`else
          6'd0);
`endif
    end

    // Drop FC init: everything clears on the next cycle
    start_fc = 1'b0;
    tick(1);
    chk("drop_fc1", fc1, 1'b0);
    chk("drop_fc2", fc2, 1'b0);
    chk("drop_hdr_p", hdr_p, 8'h00);
    chk("drop_data_np", data_np, 12'h000);
    chk("drop_cnt", err_cnt, 8'h00);
    chk("drop_tready", s_axis_tready, 1'b1);
    start_fc = 1'b1;
    tick(1);

    // Commit latency and FC1/FC2 flag timing
    send_dllp(8'h40, 8'h20, 12'h010, 2'b00, 2'b00, 1'b0);
    chk("lat_pre_hdr_p", hdr_p, 8'h00);
    chk("lat_commit_tready", s_axis_tready, 1'b0);
    tick(1);
    chk("lat_hdr_p", hdr_p, 8'h20);
    chk("lat_tready_back", s_axis_tready, 1'b1);
    send_dllp(8'h50, 8'h20, 12'h010, 2'b00, 2'b00, 1'b0);
    tick(1);
    send_dllp(8'h60, 8'h20, 12'h010, 2'b00, 2'b00, 1'b0);
    tick(1);
    chk("lat_hdr_cpl", hdr_cpl, 8'h20);
    chk("lat_fc1_early", fc1, 1'b0);
    tick(1);
    chk("lat_fc1", fc1, 1'b1);
    send_dllp(8'hC0, 8'h21, 12'h011, 2'b00, 2'b00, 1'b0);
    chk("lat_fc2_early", fc2, 1'b0);
    tick(1);
    chk("lat_fc2", fc2, 1'b1);
    chk("lat_fc2_hdr_p", hdr_p, 8'h21);

    // CRC error pulse
    send_dllp(8'h40, 8'h77, 12'h777, 2'b00, 2'b00, 1'b1);
    chk("crc_pulse", crc_err, 1'b1);
    chk("crc_cnt1", err_cnt, 8'd1);
    tick(1);
    chk("crc_pulse_end", crc_err, 1'b0);
    chk("crc_hdr_p_kept", hdr_p, 8'h21);

    // Beat 1 with tlast: malformed, then a normal DLLP is accepted
    w = make_beat1(8'h50, 8'h66, 12'h066, 2'b00, 2'b00);
    send_beat(w, 4'hF, 1'b1);
    chk("mal_pulse", malformed, 1'b1);
    tick(1);
    chk("mal_pulse_end", malformed, 1'b0);
    chk("mal_no_commit", hdr_np, 8'h20);
    send_dllp(8'h50, 8'h66, 12'h066, 2'b00, 2'b00, 1'b0);
    tick(1);
    chk("mal_recover_hdr_np", hdr_np, 8'h66);

    // Extra non-last beat while waiting for the CRC beat
    w = make_beat1(8'h60, 8'h3C, 12'hABC, 2'b00, 2'b00);
    c = ~crc_ref(w);
    send_beat(w, 4'hF, 1'b0);
    send_beat(32'hDEAD_BEEF, 4'hF, 1'b0);
    chk("mal2_pulse", malformed, 1'b1);
    send_beat({16'h0000, c}, 4'h3, 1'b1);
    tick(1);
    chk("mal2_hdr_cpl", hdr_cpl, 8'h3C);
    chk("mal2_data_cpl", data_cpl, 12'hABC);

    // Counter saturation
    for (int i = 1; i <= 300; i++) begin
      send_dllp(8'h40, 8'h99, 12'h999, 2'b00, 2'b00, 1'b1);
      if (i == 100) chk("sat_cnt_mid", err_cnt, 8'd101);
    end
    chk("sat_cnt", err_cnt, 8'hFF);
    chk("sat_hdr_p", hdr_p, 8'h21);

    // Random DLLPs against the credit model
    start_fc = 1'b0;
    tick(1);
    start_fc = 1'b1;
    tick(1);
    model_clear();
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        start_fc = 1'b0;
        tick(1);
        start_fc = 1'b1;
        tick(1);
        model_clear();
      end
      r = $urandom_range(0, 7);
      case (r)
        0: tb_t = 8'h40;
        1: tb_t = 8'h50;
        2: tb_t = 8'h60;
        3: tb_t = 8'hC0;
        4: tb_t = 8'hD0;
        5: tb_t = 8'hE0;
        default: tb_t = {5'($urandom_range(0, 31)), 3'd0};
      endcase
      if ($urandom_range(0, 5) == 0) tb_t[2:0] = 3'($urandom_range(1, 7));
      tb_h   = 8'($urandom);
      tb_d   = 12'($urandom);
      tb_hs  = 2'($urandom);
      tb_ds  = 2'($urandom);
      tb_bad = ($urandom_range(0, 4) == 0);
      send_dllp(tb_t, tb_h, tb_d, tb_hs, tb_ds, tb_bad);
      model_apply(tb_t, tb_h, tb_d, tb_hs, tb_ds, tb_bad);
      tick(2);
      model_check($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
